// File: rtl/bitonic_sorter_pipe_if.sv
// Stream interface for bitonic_sorter_pipe: an input transaction channel
// (in_val/in_rdy/in_desc/in_data) and a sorted-result channel
// (out_val/out_rdy/out_data). The master side produces inputs and consumes
// results; the slave side is the sorter.
interface bitonic_sorter_pipe_if #(
    parameter int NBITS  = 8,
    parameter int NELEMS = 4
);
    logic                    in_val;
    logic                    in_rdy;
    logic                    in_desc;
    logic [NELEMS*NBITS-1:0] in_data;
    logic                    out_val;
    logic                    out_rdy;
    logic [NELEMS*NBITS-1:0] out_data;

    modport master (
        output in_val, in_desc, in_data, out_rdy,
        input  in_rdy, out_val, out_data
    );

    modport slave (
        input  in_val, in_desc, in_data, out_rdy,
        output in_rdy, out_val, out_data
    );
endinterface

// File: rtl/bitonic_sorter_pipe.sv
// Pipelined bitonic sorting network. Each compare-exchange stage is followed
// by a register holding valid, desc and the element vector; the last stage
// drives the outputs directly.
// Optional build macro: BITONIC_SORTER_SIGNED_EN -- when defined, elements
// compare as two's-complement signed values, otherwise as unsigned.
module bitonic_sorter_pipe #(
    parameter int NBITS  = 8,
    parameter int NELEMS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bitonic_sorter_pipe_if.slave bus
);
    localparam int LOG_N   = $clog2(NELEMS);
    localparam int NSTAGES = LOG_N * (LOG_N + 1) / 2;

    typedef logic [NELEMS-1:0][NBITS-1:0] vec_t;

    // Block-size exponent p (block k = 2**p) of the merge that stage s belongs to.
    function automatic int stage_p(input int s);
        int idx;
        int res;
        idx = 0;
        res = 1;
        for (int p = 1; p <= LOG_N; p++) begin
            for (int q = p - 1; q >= 0; q--) begin
                if (idx == s) res = p;
                idx++;
            end
        end
        return res;
    endfunction

    // Partner-distance exponent q (distance j = 2**q) used by stage s.
    function automatic int stage_q(input int s);
        int idx;
        int res;
        idx = 0;
        res = 0;
        for (int p = 1; p <= LOG_N; p++) begin
            for (int q = p - 1; q >= 0; q--) begin
                if (idx == s) res = q;
                idx++;
            end
        end
        return res;
    endfunction

    // Strict "a is greater than b" in the configured number format.
    function automatic logic elem_gt(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
`ifdef BITONIC_SORTER_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    logic val_q  [NSTAGES];
    logic val_d  [NSTAGES];
    logic desc_q [NSTAGES];
    logic desc_d [NSTAGES];
    vec_t data_q [NSTAGES];
    vec_t data_d [NSTAGES];

    logic advance;
    logic src_val;
    logic src_desc;
    vec_t src_data;
    vec_t cx;
    logic asc;
    int   pj;
    int   pk;
    int   prev;

    // Handshake: a transfer happens on a rising edge where val && rdy are both
    // high. The whole pipeline moves as one (advance) whenever the last stage
    // is empty or its result is being taken; in_rdy is advance, so it depends
    // only on out_val/out_rdy and never on in_val. When not advancing every
    // stage, bubbles included, holds its contents.
    always_comb begin
        advance      = !val_q[NSTAGES-1] || bus.out_rdy;
        bus.in_rdy   = advance;
        bus.out_val  = val_q[NSTAGES-1];
        bus.out_data = data_q[NSTAGES-1];
    end

    // Per-stage compare-exchange on the previous register (or the input) and hold.
    always_comb begin
        src_val  = 1'b0;
        src_desc = 1'b0;
        src_data = '0;
        cx       = '0;
        asc      = 1'b0;
        pj       = 1;
        pk       = 2;
        prev     = 0;
        for (int s = 0; s < NSTAGES; s++) begin
            prev = (s > 0) ? s - 1 : 0;
            if (s == 0) begin
                src_val  = bus.in_val;
                src_desc = bus.in_desc;
                src_data = bus.in_data;
            end else begin
                src_val  = val_q[prev];
                src_desc = desc_q[prev];
                src_data = data_q[prev];
            end
            pj = 1 << stage_q(s);
            pk = 1 << stage_p(s);
            cx = src_data;
            for (int i = 0; i < NELEMS; i++) begin
                // Lower index of each pair owns the exchange; its direction
                // comes from the enclosing block, flipped for descending.
                if ((i ^ pj) > i) begin
                    asc = ((i & pk) == 0) ^ src_desc;
                    if (asc ? elem_gt(src_data[i], src_data[i ^ pj])
                            : elem_gt(src_data[i ^ pj], src_data[i])) begin
                        cx[i]      = src_data[i ^ pj];
                        cx[i ^ pj] = src_data[i];
                    end
                end
            end
            val_d[s]  = advance ? src_val  : val_q[s];
            desc_d[s] = advance ? src_desc : desc_q[s];
            data_d[s] = advance ? cx       : data_q[s];
        end
    end

    // Stage registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NSTAGES; s++) begin
                val_q[s]  <= 1'b0;
                desc_q[s] <= 1'b0;
                data_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NSTAGES; s++) begin
                val_q[s]  <= val_d[s];
                desc_q[s] <= desc_d[s];
                data_q[s] <= data_d[s];
            end
        end
    end
endmodule
